// File: rtl/timer_counter.sv
// Bus-mapped programmable down-counter with one-shot / auto-reload modes and a level irq.
// Register writes land on the strobe edge, rdata is combinational from addr, irq is a flop AND; no backpressure.
module timer_counter #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7f00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CNT,
    ST_INT
  } state_t;

  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  state_t      state, state_nxt;
  ctrl_t       ctrl;
  logic [31:0] preset;
  logic [31:0] count, count_nxt;
  logic        irq_flag;
  logic        flag_set, flag_clr, en_clr;
  logic        hit, wr_en, ctrl_wr, preset_wr;
  logic        addr_unused;

  assign hit         = (addr[31:4] == BASE_ADDR[31:4]);
  assign wr_en       = hit && (byteen == 4'b1111);
  assign ctrl_wr     = wr_en && (addr[3:2] == 2'd0);
  assign preset_wr   = wr_en && (addr[3:2] == 2'd1);
  assign addr_unused = ^addr[1:0];

  // FSM acts on the registered CTRL; a same-edge CPU write is merged in the register block.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    flag_set  = 1'b0;
    flag_clr  = 1'b0;
    en_clr    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ctrl.en) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        count_nxt = preset;
        state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl.en) begin
          state_nxt = ST_IDLE;
        end else if (count > 32'd1) begin
          count_nxt = count - 32'd1;
        end else begin
          count_nxt = 32'd0;
          flag_set  = 1'b1;
          state_nxt = ST_INT;
        end
      end
      ST_INT: begin
        if (ctrl.mode == 2'd1) begin
          flag_clr  = 1'b1;
          state_nxt = ST_LOAD;
        end else begin
          en_clr    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (ctrl_wr) begin
        ctrl <= ctrl_t'(wdata[3:0]);
      end else if (en_clr) begin
        ctrl.en <= 1'b0;
      end
      if (preset_wr) preset <= wdata;
      // A CTRL write acknowledges the interrupt even if the counter expires on the same edge.
      if (ctrl_wr || flag_clr) begin
        irq_flag <= 1'b0;
      end else if (flag_set) begin
        irq_flag <= 1'b1;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (addr[3:2])
        2'd0:    rdata = {28'd0, ctrl};
        2'd1:    rdata = preset;
        2'd2:    rdata = count;
        default: rdata = '0;
      endcase
    end
  end

  assign irq = irq_flag & ctrl.im;

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: directed literal checks plus randomized traffic against a cycle model.
module tb_timer_counter;

  localparam logic [31:0] BASE = 32'h0000_7f00;
  localparam int P_IDLE = 0, P_LOAD = 1, P_CNT = 2, P_INT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

  timer_counter #(.BASE_ADDR(BASE)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [1:0]  mode;
    logic        im;
    logic [31:0] preset;
    logic [31:0] count;
    logic        flag;
    int          phase;
  } mstate_t;

  mstate_t m = '{en: 1'b0, mode: 2'd0, im: 1'b0, preset: 32'd0, count: 32'd0, flag: 1'b0, phase: P_IDLE};

  function automatic mstate_t model_next(input mstate_t s, input logic rst, input logic [31:0] a,
                                         input logic [3:0] be, input logic [31:0] wd);
    mstate_t n;
    bit      wr;
    n = s;
    if (rst) begin
      n.en = 0; n.mode = 0; n.im = 0; n.preset = 0; n.count = 0; n.flag = 0; n.phase = P_IDLE;
      return n;
    end
    case (s.phase)
      P_IDLE: if (s.en) n.phase = P_LOAD;
      P_LOAD: begin n.count = s.preset; n.phase = P_CNT; end
      P_CNT: begin
        if (!s.en) n.phase = P_IDLE;
        else if (s.count > 1) n.count = s.count - 1;
        else begin n.count = 0; n.flag = 1; n.phase = P_INT; end
      end
      default: begin
        if (s.mode == 2'd1) begin n.flag = 0; n.phase = P_LOAD; end
        else begin n.en = 0; n.phase = P_IDLE; end
      end
    endcase
    wr = (a[31:4] == BASE[31:4]) && (be == 4'hF);
    if (wr && a[3:2] == 2'd0) begin
      n.en = wd[0]; n.mode = wd[2:1]; n.im = wd[3]; n.flag = 0;
    end
    if (wr && a[3:2] == 2'd1) n.preset = wd;
    return n;
  endfunction

  function automatic logic [31:0] model_rdata(input mstate_t s, input logic [31:0] a);
    if (a[31:4] != BASE[31:4]) return 32'd0;
    case (a[3:2])
      2'd0:    return {28'd0, s.im, s.mode, s.en};
      2'd1:    return s.preset;
      2'd2:    return s.count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) m <= model_next(m, reset, addr, byteen, wdata);

  always @(negedge clk) begin
    chk("model rdata", rdata, model_rdata(m, addr));
    chk("model irq", {31'd0, irq}, {31'd0, m.flag & m.im});
  end

  task automatic drive(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    addr = a; byteen = be; wdata = wd;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] v);
    drive(BASE + {28'd0, off}, 4'hF, v);
  endtask

  task automatic step();
    drive(BASE + 32'h8, 4'h0, 32'd0);
  endtask

  // Checks the state left by the most recent edge without advancing time past the next edge.
  task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a; byteen = 4'h0; wdata = 32'd0;
    #1;
    chk(name, rdata, exp);
  endtask

  task automatic peek_irq(input string name, input logic exp);
    #1;
    chk(name, {31'd0, irq}, {31'd0, exp});
  endtask

  task automatic settle();
    wr(4'h0, 32'd0);
    repeat (4) step();
  endtask

  initial begin
    reset = 1'b1; addr = 32'd0; byteen = 4'h0; wdata = 32'd0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;

    peek("rst ctrl", BASE + 32'h0, 32'd0);
    peek("rst preset", BASE + 32'h4, 32'd0);
    peek("rst count", BASE + 32'h8, 32'd0);
    peek("rst resv", BASE + 32'hC, 32'd0);
    peek_irq("rst irq", 1'b0);

    wr(4'h4, 32'h1234);
    peek("preset rw", BASE + 32'h4, 32'h1234);
    drive(BASE + 32'h4, 4'b0011, 32'hFFFF_FFFF);
    peek("partial byteen", BASE + 32'h4, 32'h1234);

    // One-shot, PRESET=3: write at edge k.
    wr(4'h4, 32'd3);
    wr(4'h0, 32'h9);
    step(); step();
    peek("os k+2", BASE + 32'h8, 32'd3); step();
    peek("os k+3", BASE + 32'h8, 32'd2); step();
    peek("os k+4", BASE + 32'h8, 32'd1); peek_irq("os irq k+4", 1'b0); step();
    peek("os k+5", BASE + 32'h8, 32'd0); peek_irq("os irq k+5", 1'b1); step();
    peek("os en clr", BASE + 32'h0, 32'h8); peek_irq("os irq held", 1'b1); step();
    peek_irq("os irq held2", 1'b1);
    wr(4'h0, 32'd0);
    peek_irq("os irq ack", 1'b0);
    repeat (2) step();

    // Auto-reload, PRESET=2.
    wr(4'h4, 32'd2);
    wr(4'h0, 32'hB);
    step(); step(); step();
    for (int p = 0; p < 3; p++) begin
      step(); peek("ar cnt0", BASE + 32'h8, 32'd0); peek_irq("ar pulse", 1'b1);
      step(); peek("ar cnt int", BASE + 32'h8, 32'd0); peek_irq("ar low1", 1'b0);
      step(); peek("ar reload", BASE + 32'h8, 32'd2); peek_irq("ar low2", 1'b0);
      step(); peek("ar cnt1", BASE + 32'h8, 32'd1); peek_irq("ar low3", 1'b0);
    end
    settle();

    // Masked one-shot: flag sets but irq stays low, then a CTRL write clears it.
    wr(4'h4, 32'd1);
    wr(4'h0, 32'h1);
    repeat (4) step();
    peek_irq("masked irq", 1'b0);
    wr(4'h0, 32'h8);
    peek_irq("masked ack", 1'b0);
    step();
    peek_irq("masked ack2", 1'b0);
    settle();

    // Pause at COUNT=5 with PRESET=10: counter freezes at 4.
    wr(4'h4, 32'd10);
    wr(4'h0, 32'h9);
    repeat (7) step();
    peek("pause pre", BASE + 32'h8, 32'd5);
    wr(4'h0, 32'h8);
    peek("pause edge", BASE + 32'h8, 32'd4);
    step(); peek("pause frz1", BASE + 32'h8, 32'd4);
    step(); peek("pause frz2", BASE + 32'h8, 32'd4);
    wr(4'h0, 32'h9);
    step(); step();
    peek("resume load", BASE + 32'h8, 32'd10);
    settle();

    // PRESET=0 one-shot.
    wr(4'h4, 32'd0);
    wr(4'h0, 32'h9);
    step(); step();
    peek_irq("p0 k+2", 1'b0);
    step();
    peek_irq("p0 k+3", 1'b1);
    settle();

    // Ignored writes and out-of-window access.
    peek("cnt before", BASE + 32'h8, 32'd0);
    wr(4'h8, 32'hDEAD_BEEF);
    peek("count ro", BASE + 32'h8, 32'd0);
    wr(4'hC, 32'hDEAD_BEEF);
    peek("resv ro", BASE + 32'hC, 32'd0);
    drive(BASE + 32'h10, 4'hF, 32'h9);
    peek("outside rd", BASE + 32'h10, 32'd0);
    peek("outside wr", BASE + 32'h0, 32'd0);

    // Reset mid-count at COUNT=7.
    wr(4'h4, 32'd20);
    wr(4'h0, 32'h9);
    repeat (15) step();
    peek("pre rst", BASE + 32'h8, 32'd7);
    reset = 1'b1;
    step();
    reset = 1'b0;
    peek("mid rst count", BASE + 32'h8, 32'd0);
    peek("mid rst ctrl", BASE + 32'h0, 32'd0);
    peek("mid rst preset", BASE + 32'h4, 32'd0);
    step(); step();
    peek("mid rst idle", BASE + 32'h8, 32'd0);

    // CTRL write on the mode-0 INT edge, then a PRESET write during CNT.
    wr(4'h4, 32'd2);
    wr(4'h0, 32'h9);
    repeat (4) step();
    peek_irq("cf int", 1'b1);
    wr(4'h0, 32'h9);
    peek("cf en kept", BASE + 32'h0, 32'h9);
    peek_irq("cf flag clr", 1'b0);
    step(); peek("cf idle", BASE + 32'h8, 32'd0);
    step(); peek("cf reload", BASE + 32'h8, 32'd2);
    wr(4'h4, 32'd50);
    peek("cf preset cnt", BASE + 32'h8, 32'd1);
    step(); peek("cf expire", BASE + 32'h8, 32'd0);
    step(); peek("cf en clr", BASE + 32'h0, 32'h8);
    wr(4'h0, 32'h9);
    step(); step();
    peek("cf new preset", BASE + 32'h8, 32'd50);
    settle();

    // Randomized traffic; the negedge compare checks every cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      int          sel;
      logic [31:0] a;
      logic [3:0]  be;
      logic [31:0] wd;
      sel = int'($urandom_range(0, 99));
      a   = BASE + {28'd0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      be  = 4'h0;
      wd  = $urandom;
      if (sel < 3) a = BASE + 32'h10 + {28'd0, 4'($urandom_range(0, 15))};
      else if (sel < 5) a = $urandom;
      if (sel >= 70) begin
        be = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'hF;
        if (a[3:2] == 2'd1) wd = 32'($urandom_range(0, 12));
      end
      reset = ($urandom_range(0, 299) == 0);
      drive(a, be, wd);
      reset = 1'b0;
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
